// File: rtl/alu_uart_sequencer.sv
// -----------------------------------------------------------------------------
// alu_uart_sequencer
//
// Collects a three-byte command from a UART receiver (operand A, operand B,
// opcode), presents it to an external combinational ALU, and hands the ALU
// result to a UART transmitter as a single byte.
//
// Parameters
//   size     data width of operands, result and UART bytes (must be >= 6)
//   TIMEOUT  idle clocks tolerated between bytes of one command
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   rx_data      received byte, valid while rx_done=1
//   rx_done      one-cycle pulse per received byte
//   tx_busy      transmitter busy while a byte is shifting out
//   alu_result   combinational ALU result
//   alu_a/alu_b  registered operands to the ALU
//   alu_op       registered 6-bit ALU opcode
//   tx_data      registered byte to the transmitter
//   tx_start     one-cycle pulse requesting transmission of tx_data
//   overrun      sticky: a byte arrived while a result was in flight
//   timeout_err  sticky: a partial command was abandoned after TIMEOUT idles
// -----------------------------------------------------------------------------
module alu_uart_sequencer #(
  parameter int size    = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] rx_data,
  input  logic            rx_done,
  input  logic            tx_busy,
  input  logic [size-1:0] alu_result,
  output logic [size-1:0] alu_a,
  output logic [size-1:0] alu_b,
  output logic [5:0]      alu_op,
  output logic [size-1:0] tx_data,
  output logic            tx_start,
  output logic            overrun,
  output logic            timeout_err
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EVAL,
    SEND,
    WAIT_TX
  } state_t;

  state_t            state_q, state_d;
  logic [size-1:0]   alu_a_q, alu_a_d;
  logic [size-1:0]   alu_b_q, alu_b_d;
  logic [5:0]        alu_op_q, alu_op_d;
  logic [size-1:0]   tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              overrun_q, overrun_d;
  logic              timeout_err_q, timeout_err_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [IDLE_W-1:0] idle_inc;
  // Handshake tracking in WAIT_TX: whether the transmitter has gone busy yet,
  // and whether one WAIT_TX cycle has already passed without it doing so.
  logic              busy_seen_q, busy_seen_d;
  logic              no_busy_q, no_busy_d;

  // Saturating increment; the counter can never wrap back to zero.
  assign idle_inc = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    idle_d        = idle_q;
    busy_seen_d   = busy_seen_q;
    no_busy_d     = no_busy_q;

    case (state_q)
      WAIT_A: begin
        idle_d = '0;
        if (rx_done) begin
          alu_a_d = rx_data;
          state_d = WAIT_B;
        end
      end

      WAIT_B, WAIT_OP: begin
        // A byte landing in the same cycle the counter hits TIMEOUT wins.
        if (rx_done) begin
          idle_d = '0;
          if (state_q == WAIT_B) begin
            alu_b_d = rx_data;
            state_d = WAIT_OP;
          end else begin
            alu_op_d = rx_data[5:0];
            state_d  = EVAL;
          end
        end else if (idle_q == IDLE_MAX) begin
          // Abandon the partial command; operand registers keep their values.
          timeout_err_d = 1'b1;
          idle_d        = '0;
          state_d       = WAIT_A;
        end else begin
          idle_d = idle_inc;
        end
      end

      EVAL: begin
        // ALU has had a full cycle on the new operands; capture its result.
        tx_data_d = alu_result;
        state_d   = SEND;
      end

      SEND: begin
        if (!tx_busy) begin
          tx_start_d  = 1'b1;
          busy_seen_d = 1'b0;
          no_busy_d   = 1'b0;
          state_d     = WAIT_TX;
        end
      end

      WAIT_TX: begin
        if (tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q || no_busy_q) begin
          // Either the transmission finished, or the transmitter never
          // acknowledged within two cycles.
          state_d = WAIT_A;
        end else begin
          no_busy_d = 1'b1;
        end
      end

      default: state_d = WAIT_A;
    endcase

    if (rx_done && (state_q == EVAL || state_q == SEND || state_q == WAIT_TX)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_A;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= 6'b000000;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      idle_q        <= '0;
      busy_seen_q   <= 1'b0;
      no_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      idle_q        <= idle_d;
      busy_seen_q   <= busy_seen_d;
      no_busy_q     <= no_busy_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_sequencer
//
// Bench for alu_uart_sequencer: a small behavioural ALU and an optional
// transmitter model surround the DUT. A table of commands with hand-computed
// results is played through first, followed by directed sequences for the
// busy-hold, timeout, overrun and mid-command reset cases.
// -----------------------------------------------------------------------------
module tb_alu_uart_sequencer;

  localparam int W       = 8;
  localparam int TIMEOUT = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] rx_data;
  logic         rx_done;
  logic         tx_busy;
  logic [W-1:0] alu_result;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [5:0]   alu_op;
  logic [W-1:0] tx_data;
  logic         tx_start;
  logic         overrun;
  logic         timeout_err;

  logic         tx_busy_man;
  logic         tx_auto;
  int           tx_cnt = 0;
  int           pulse_cnt = 0;
  logic         start_prev = 1'b0;
  logic         dbl_pulse = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  alu_uart_sequencer #(
    .size    (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .tx_busy     (tx_busy),
    .alu_result  (alu_result),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU using MIPS-style function codes.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      6'h20: alu_result = alu_a + alu_b;
      6'h22: alu_result = alu_a - alu_b;
      6'h24: alu_result = alu_a & alu_b;
      6'h25: alu_result = alu_a | alu_b;
      6'h26: alu_result = alu_a ^ alu_b;
      6'h2A: alu_result = {7'b0, ($signed(alu_a) < $signed(alu_b))};
      6'h00: alu_result = alu_a << alu_b[2:0];
      6'h02: alu_result = alu_a >> alu_b[2:0];
      6'h03: alu_result = W'($signed(alu_a) >>> alu_b[2:0]);
      default: alu_result = '0;
    endcase
  end

  // Transmitter model: busy for 6 cycles after an accepted tx_start.
  always @(posedge clk) begin
    if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    else if (tx_auto && tx_start) tx_cnt <= 6;
  end

  assign tx_busy = tx_busy_man | (tx_cnt != 0);

  always @(posedge clk) begin
    if (tx_start) pulse_cnt <= pulse_cnt + 1;
    if (tx_start && start_prev) dbl_pulse <= 1'b1;
    start_prev <= tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Wait until the transmitter is idle, then give the DUT time to return to
  // WAIT_A.
  task automatic settle();
    for (int i = 0; i < 100 && tx_busy; i++) tick();
    check("tx_idle_bound", tx_busy, 1'b0);
    repeat (3) tick();
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] exp, input logic auto_tx);
    int lat;
    tx_auto = auto_tx;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    lat = 1;
    while (tx_start !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    $display("cmd a=%02h b=%02h op=%02h -> tx_data=%02h (expect %02h) latency=%0d",
             a, b, op, tx_data, exp, lat);
    check("latency", lat, 3);
    check("tx_data", tx_data, exp);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", alu_op, op & 8'h3F);
    tick();
    check("tx_start_width", tx_start, 1'b0);
    settle();
    // Operands persist after the transmission completes.
    check("alu_a_hold", alu_a, a);
    check("alu_op_hold", alu_op, op & 8'h3F);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
    logic       auto_tx;
  } vec_t;

  vec_t vecs[11];
  int   bad;
  int   pulses_before;

  initial begin
    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0};  // ADD
    vecs[1]  = '{8'h03, 8'h05, 8'h22, 8'hFE, 1'b0};  // SUB, negative
    vecs[2]  = '{8'h80, 8'h02, 8'h03, 8'hE0, 1'b0};  // SRA sign fill
    vecs[3]  = '{8'h0C, 8'h0A, 8'h24, 8'h08, 1'b1};  // AND, real tx handshake
    vecs[4]  = '{8'h0C, 8'h0A, 8'h25, 8'h0E, 1'b1};  // OR
    vecs[5]  = '{8'h7F, 8'h01, 8'h20, 8'h80, 1'b0};  // ADD wraps
    vecs[6]  = '{8'h01, 8'h03, 8'h00, 8'h08, 1'b0};  // SLL
    vecs[7]  = '{8'hF0, 8'h04, 8'h02, 8'h0F, 1'b1};  // SRL zero fill
    vecs[8]  = '{8'hFF, 8'h01, 8'h2A, 8'h01, 1'b0};  // SLT signed
    vecs[9]  = '{8'h12, 8'h34, 8'hE0, 8'h46, 1'b0};  // upper op bits ignored -> ADD
    vecs[10] = '{8'h5A, 8'hFF, 8'h26, 8'hA5, 1'b0};  // XOR

    clk         = 1'b0;
    reset       = 1'b1;
    rx_data     = '0;
    rx_done     = 1'b0;
    tx_busy_man = 1'b0;
    tx_auto     = 1'b0;

    repeat (3) tick();
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_op", alu_op, 6'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    tick();

    // Table-driven commands.
    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].auto_tx);
    end
    tx_auto = 1'b0;

    // Timeout: one byte then silence. Operands B/op keep the last command.
    check("timeout_err_pre", timeout_err, 1'b0);
    send_byte(8'h11);
    repeat (15) tick();
    check("timeout_err_early", timeout_err, 1'b0);
    repeat (5) tick();
    $display("timeout seq: timeout_err=%0b alu_a=%02h alu_b=%02h alu_op=%02h",
             timeout_err, alu_a, alu_b, alu_op);
    check("timeout_err_set", timeout_err, 1'b1);
    check("timeout_alu_a", alu_a, 8'h11);
    check("timeout_alu_b", alu_b, 8'hFF);
    check("timeout_alu_op", alu_op, 6'h26);
    run_cmd(8'h01, 8'h01, 8'h20, 8'h02, 1'b0);
    check("timeout_err_sticky", timeout_err, 1'b1);

    // tx_busy held high across SEND.
    send_byte(8'h05);
    send_byte(8'h03);
    tx_busy_man = 1'b1;
    send_byte(8'h20);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_start !== 1'b0) bad++;
    end
    tx_busy_man = 1'b0;
    check("busy_hold_no_start", bad, 0);
    tick();
    $display("busy hold: tx_start=%0b tx_data=%02h after release", tx_start, tx_data);
    check("busy_release_start", tx_start, 1'b1);
    check("busy_release_data", tx_data, 8'h08);
    tick();
    check("busy_release_width", tx_start, 1'b0);
    settle();

    // Overrun: byte arrives while in SEND.
    check("overrun_pre", overrun, 1'b0);
    send_byte(8'h0C);
    send_byte(8'h0A);
    send_byte(8'h25);
    tick();                       // now in SEND
    send_byte(8'hAA);             // dropped
    $display("overrun seq: overrun=%0b tx_start=%0b tx_data=%02h alu_a=%02h",
             overrun, tx_start, tx_data, alu_a);
    check("overrun_set", overrun, 1'b1);
    check("overrun_tx_start", tx_start, 1'b1);
    check("overrun_tx_data", tx_data, 8'h0E);
    check("overrun_alu_a", alu_a, 8'h0C);
    tick();
    settle();
    run_cmd(8'h02, 8'h03, 8'h20, 8'h05, 1'b0);
    check("overrun_sticky", overrun, 1'b1);

    // Reset mid-command, coinciding with an incoming byte.
    send_byte(8'h7F);
    reset   = 1'b1;
    rx_data = 8'h55;
    rx_done = 1'b1;
    tick();
    reset   = 1'b0;
    rx_done = 1'b0;
    $display("mid reset: alu_a=%02h alu_b=%02h alu_op=%02h tx_data=%02h flags=%0b%0b%0b",
             alu_a, alu_b, alu_op, tx_data, tx_start, overrun, timeout_err);
    check("mrst_alu_a", alu_a, 8'h00);
    check("mrst_alu_b", alu_b, 8'h00);
    check("mrst_alu_op", alu_op, 6'h00);
    check("mrst_tx_data", tx_data, 8'h00);
    check("mrst_tx_start", tx_start, 1'b0);
    check("mrst_overrun", overrun, 1'b0);
    check("mrst_timeout_err", timeout_err, 1'b0);
    pulses_before = pulse_cnt;
    repeat (10) tick();
    check("mrst_no_start", pulse_cnt, pulses_before);
    run_cmd(8'h01, 8'h02, 8'h25, 8'h03, 1'b0);

    check("tx_start_consecutive", dbl_pulse, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
